half_duplex_spi_master_mc: RTL and testbench

- Next-generation 3-wire half-duplex SPI master.
- Runs on a single fabric clock with an internal clock-enable divider, so no derived clock domain is used.
- Adds four things:
  - a runtime-programmable divider;
  - multiple chip selects;
  - a start/busy/done handshake;
  - per-bit direction control.
- Sits between register-mapped control logic and external converter/synthesiser configuration ports. The top level owns the sdio pad buffer.

---
 rtl/half_duplex_spi_master_mc.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_half_duplex_spi_master_mc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_duplex_spi_master_mc.sv
// -----------------------------------------------------------------------------
// half_duplex_spi_master_mc
//
// Purpose:
//   3-wire half-duplex SPI master for configuring converters and synthesisers.
//   Everything runs on fabric_clk. SCLK is produced by an internal
//   half-period counter, not by a derived clock. A start/busy/done handshake
//   hands a transaction to the shifter. A per-bit read/write mask decides
//   whether the master drives the shared sdio line or releases it and
//   samples it.
//
// Parameters:
//   DATA_WIDTH            maximum bits per transaction
//   TRANSACTION_LEN_WIDTH width of transaction_length (must hold DATA_WIDTH)
//   NUM_CS                number of chip-select outputs (>= 2)
//   DIV_WIDTH             width of clk_div
//
// Ports:
//   fabric_clk            system clock
//   reset                 synchronous active-high reset
//   start                 one-cycle request, accepted only while busy=0
//   cs_sel                chip-select index (clamped to NUM_CS-1)
//   clk_div               SCLK half period H in fabric_clk cycles (0 -> 1)
//   spi_cpol / spi_cpha   SPI mode
//   transaction_length    bit count N (clamped to DATA_WIDTH)
//   transaction_data      write data, bit N-1 is sent first
//   transaction_rw_mask   per bit: 1 = master drives, 0 = master samples
//   busy                  transaction in progress
//   done                  one-cycle completion pulse
//   transaction_read_data captured read bits, right-aligned
//   spi_sclk, spi_cs_n    registered serial clock and active-low selects
//   spi_sdio_out/_oe      pad drive value / enable
//   spi_sdio_in           pad input
// -----------------------------------------------------------------------------
module half_duplex_spi_master_mc #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int NUM_CS                = 4,
  parameter int DIV_WIDTH             = 8
) (
  input  logic                             fabric_clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [$clog2(NUM_CS)-1:0]        cs_sel,
  input  logic [DIV_WIDTH-1:0]             clk_div,
  input  logic                             spi_cpol,
  input  logic                             spi_cpha,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  input  logic [DATA_WIDTH-1:0]            transaction_data,
  input  logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            transaction_read_data,
  output logic                             spi_sclk,
  output logic [NUM_CS-1:0]                spi_cs_n,
  output logic                             spi_sdio_out,
  output logic                             spi_sdio_oe,
  input  logic                             spi_sdio_in
);

  localparam int CS_W   = $clog2(NUM_CS);
  localparam int IDX_W  = $clog2(DATA_WIDTH);
  localparam int EDGE_W = TRANSACTION_LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t                           r_state;
  logic                             r_busy;
  logic                             r_done;
  logic [DATA_WIDTH-1:0]            r_rd_data;
  logic                             r_sclk;
  logic [NUM_CS-1:0]                r_cs_n;
  logic                             r_sdio_out;
  logic                             r_sdio_oe;

  // Transaction parameters captured on accept.
  logic                             r_cpol;
  logic                             r_cpha;
  logic [CS_W-1:0]                  r_cs_sel;
  logic [DIV_WIDTH-1:0]             r_h;
  logic [TRANSACTION_LEN_WIDTH-1:0] r_n;
  logic [DATA_WIDTH-1:0]            r_data;
  logic [DATA_WIDTH-1:0]            r_mask;

  // Shift machinery.
  logic [DATA_WIDTH-1:0]            r_rx;
  logic [DIV_WIDTH-1:0]             r_cnt;   // cycles left in the current H slot
  logic [EDGE_W-1:0]                r_edge;  // SCLK edges already produced

  // ---------------------------------------------------------------------------
  // Clamping of the request fields, applied as they are latched
  // ---------------------------------------------------------------------------
  logic [CS_W-1:0]                  w_cs_clamped;
  logic [TRANSACTION_LEN_WIDTH-1:0] w_len_clamped;
  logic [DIV_WIDTH-1:0]             w_div_clamped;

  generate
    if ((1 << CS_W) > NUM_CS) begin : g_cs_clamp
      assign w_cs_clamped = (int'(cs_sel) > NUM_CS - 1) ? CS_W'(NUM_CS - 1) : cs_sel;
    end else begin : g_cs_pass
      // Every encodable index is a real select line, nothing to clamp.
      assign w_cs_clamped = cs_sel;
    end
  endgenerate

  assign w_len_clamped = (int'(transaction_length) > DATA_WIDTH) ?
                         TRANSACTION_LEN_WIDTH'(DATA_WIDTH) : transaction_length;
  assign w_div_clamped = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;

  // ---------------------------------------------------------------------------
  // Chip-select decode (active low, exactly one line low while selected)
  // ---------------------------------------------------------------------------
  logic [NUM_CS-1:0] w_cs_dec_n;

  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign w_cs_dec_n[gi] = (r_cs_sel != CS_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge bookkeeping
  //   Edge k (1-based) belongs to bit pair (k-1)/2, i.e. bit N-1-(k-1)/2.
  //   CPHA=0 samples on odd edges and drives on even ones.
  //   CPHA=1 does the opposite.
  // ---------------------------------------------------------------------------
  logic [EDGE_W-1:0] w_next_edge;
  logic              w_last_edge;
  logic              w_final_edge_next;
  logic              w_sample_edge;
  logic [IDX_W-1:0]  w_bit;
  logic [IDX_W-1:0]  w_bit_nxt;
  logic [IDX_W-1:0]  w_top_bit;
  logic [DIV_WIDTH-1:0] w_h_m1;

  assign w_next_edge       = r_edge + EDGE_W'(1);
  assign w_last_edge       = (r_edge == {r_n, 1'b0});
  assign w_final_edge_next = (w_next_edge == {r_n, 1'b0});
  assign w_sample_edge     = w_next_edge[0] ^ r_cpha;
  assign w_bit             = IDX_W'(EDGE_W'(r_n) - EDGE_W'(1) - (r_edge >> 1));
  assign w_bit_nxt         = w_bit - IDX_W'(1);
  assign w_top_bit         = IDX_W'(r_n - TRANSACTION_LEN_WIDTH'(1));
  assign w_h_m1            = r_h - DIV_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Controller: single registered FSM, all pad-facing outputs are flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= '1;
      r_sdio_out <= 1'b0;
      r_sdio_oe  <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_cs_sel   <= '0;
      r_h        <= DIV_WIDTH'(1);
      r_n        <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_rx       <= '0;
      r_cnt      <= '0;
      r_edge     <= '0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cpol   <= spi_cpol;
            r_cpha   <= spi_cpha;
            r_cs_sel <= w_cs_clamped;
            r_h      <= w_div_clamped;
            r_n      <= w_len_clamped;
            r_data   <= transaction_data;
            r_mask   <= transaction_rw_mask;
            r_busy   <= 1'b1;
            r_sclk   <= spi_cpol;
            r_state  <= ST_LOAD;
          end
        end

        // One cycle between accept and CS assertion. A zero-length request
        // completes from here without touching CS or SCLK.
        ST_LOAD: begin
          r_rx   <= '0;
          r_edge <= '0;
          r_cnt  <= w_h_m1;
          if (r_n == '0) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_rd_data <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_cs_n  <= w_cs_dec_n;
            r_state <= ST_SETUP;
            if (!r_cpha) begin
              // CPHA=0: the first bit must be on the line before edge 1.
              r_sdio_oe  <= r_mask[w_top_bit];
              r_sdio_out <= r_mask[w_top_bit] & r_data[w_top_bit];
            end
          end
        end

        // SETUP and SHIFT share the slot timer. The end of SETUP produces
        // edge 1. Each later slot end produces the next edge, until all 2N
        // edges have been produced.
        ST_SETUP, ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else if (r_state == ST_SHIFT && w_last_edge) begin
            r_cnt      <= w_h_m1;
            r_sdio_oe  <= 1'b0;
            r_sdio_out <= 1'b0;
            r_state    <= ST_HOLD;
          end else begin
            r_sclk  <= ~r_sclk;
            r_edge  <= w_next_edge;
            r_cnt   <= w_h_m1;
            r_state <= ST_SHIFT;
            if (w_sample_edge) begin
              // Driven positions stay 0 in the read word.
              if (!r_mask[w_bit]) begin
                r_rx[w_bit] <= spi_sdio_in;
              end
            end else if (r_cpha) begin
              r_sdio_oe  <= r_mask[w_bit];
              r_sdio_out <= r_mask[w_bit] & r_data[w_bit];
            end else if (w_final_edge_next) begin
              // CPHA=0: the last even edge has no following bit to present.
              r_sdio_oe  <= 1'b0;
              r_sdio_out <= 1'b0;
            end else begin
              r_sdio_oe  <= r_mask[w_bit_nxt];
              r_sdio_out <= r_mask[w_bit_nxt] & r_data[w_bit_nxt];
            end
          end
        end

        ST_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else begin
            r_cs_n  <= '1;
            r_cnt   <= w_h_m1;
            r_state <= ST_GAP;
            // With H=1 the first GAP cycle is also the last one.
            if (r_h == DIV_WIDTH'(1)) begin
              r_done    <= 1'b1;
              r_rd_data <= r_rx;
            end
          end
        end

        ST_GAP: begin
          // done is timed to land on the final GAP cycle.
          if (r_cnt == DIV_WIDTH'(1)) begin
            r_done    <= 1'b1;
            r_rd_data <= r_rx;
          end
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy                  = r_busy;
  assign done                  = r_done;
  assign transaction_read_data = r_rd_data;
  assign spi_sclk              = r_sclk;
  assign spi_cs_n              = r_cs_n;
  assign spi_sdio_out          = r_sdio_out;
  assign spi_sdio_oe           = r_sdio_oe;

endmodule

// File: tb/tb_half_duplex_spi_master_mc.sv
// -----------------------------------------------------------------------------
// tb_half_duplex_spi_master_mc
//
// Directed bench for half_duplex_spi_master_mc. A negedge monitor counts
// cycles, done pulses and CS/OE activity. It also plays a mode-matched
// slave: it captures the driven bits and returns a response word on
// released bits.
// -----------------------------------------------------------------------------
module tb_half_duplex_spi_master_mc;

  logic        fabric_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cs_sel = '0;
  logic [7:0]  clk_div = 8'd1;
  logic        spi_cpol = 1'b0;
  logic        spi_cpha = 1'b0;
  logic [5:0]  transaction_length = '0;
  logic [31:0] transaction_data = '0;
  logic [31:0] transaction_rw_mask = '0;
  logic        busy;
  logic        done;
  logic [31:0] transaction_read_data;
  logic        spi_sclk;
  logic [3:0]  spi_cs_n;
  logic        spi_sdio_out;
  logic        spi_sdio_oe;
  logic        spi_sdio_in = 1'b0;

  half_duplex_spi_master_mc dut (
    .fabric_clk            (fabric_clk),
    .reset                 (reset),
    .start                 (start),
    .cs_sel                (cs_sel),
    .clk_div               (clk_div),
    .spi_cpol              (spi_cpol),
    .spi_cpha              (spi_cpha),
    .transaction_length    (transaction_length),
    .transaction_data      (transaction_data),
    .transaction_rw_mask   (transaction_rw_mask),
    .busy                  (busy),
    .done                  (done),
    .transaction_read_data (transaction_read_data),
    .spi_sclk              (spi_sclk),
    .spi_cs_n              (spi_cs_n),
    .spi_sdio_out          (spi_sdio_out),
    .spi_sdio_oe           (spi_sdio_oe),
    .spi_sdio_in           (spi_sdio_in)
  );

  always #5 fabric_clk = ~fabric_clk;

  int errors = 0;
  int checks = 0;

  // Monitor state (written only by the monitor process)
  int          m_cycle = 0;
  int          m_acc_cycle = 0;
  int          m_done_cycle = 0;
  int          m_done_cnt = 0;
  int          m_busy_cnt = 0;
  int          m_cs_lo = 0;
  int          m_oe = 0;
  int          m_contend = 0;
  int          m_rise = 0;
  logic [3:0]  m_cs_val = 4'hF;
  logic        m_sclk_idle = 1'b0;
  logic [31:0] s_rx = '0;
  int          s_edge = 0;
  logic        s_cs_prev = 1'b0;
  logic        s_sclk_prev = 1'b0;

  // Slave configuration (written only by the stimulus process)
  int          s_n = 0;
  logic        s_cpha = 1'b0;
  logic [31:0] s_resp = '0;

  // Per-transaction results
  int          res_done, res_lat, res_cs, res_oe, res_rise, res_busy, res_contend;
  logic        res_sclk_end;

  always @(negedge fabric_clk) begin
    int b;
    m_cycle++;
    if (start && !busy && !reset) m_acc_cycle = m_cycle;
    if (done) begin
      m_done_cnt++;
      m_done_cycle = m_cycle;
    end
    if (busy) m_busy_cnt++;
    if (spi_cs_n != 4'hF) begin
      m_cs_lo++;
      m_cs_val = spi_cs_n;
    end
    if (spi_sdio_oe) m_oe++;
    if (spi_sdio_oe && spi_cs_n == 4'hF) m_contend++;

    if (spi_cs_n != 4'hF && !s_cs_prev) begin
      s_edge = 0;
      s_rx = '0;
      m_sclk_idle = spi_sclk;
      spi_sdio_in = (!s_cpha && s_n > 0) ? s_resp[s_n-1] : 1'b0;
    end else if (spi_cs_n != 4'hF && spi_sclk != s_sclk_prev) begin
      s_edge++;
      if (spi_sclk && !s_sclk_prev) m_rise++;
      if ((s_edge % 2 == 1) != s_cpha) begin
        s_rx = {s_rx[30:0], spi_sdio_oe ? spi_sdio_out : 1'b0};
      end else begin
        b = s_cpha ? (s_n - 1 - (s_edge - 1) / 2) : (s_n - 1 - s_edge / 2);
        spi_sdio_in = (b >= 0) ? s_resp[b] : 1'b0;
      end
    end
    s_cs_prev = (spi_cs_n != 4'hF);
    s_sclk_prev = spi_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] cs, input logic [7:0] div, input logic cpol,
                         input logic cpha, input logic [5:0] len, input logic [31:0] data,
                         input logic [31:0] mask, input logic [31:0] resp, input int n_eff,
                         input bit dbl);
    int d0, cs0, oe0, rise0, busy0, ct0;
    @(posedge fabric_clk); #1;
    cs_sel = cs; clk_div = div; spi_cpol = cpol; spi_cpha = cpha;
    transaction_length = len; transaction_data = data; transaction_rw_mask = mask;
    s_n = n_eff; s_cpha = cpha; s_resp = resp;
    d0 = m_done_cnt; cs0 = m_cs_lo; oe0 = m_oe; rise0 = m_rise; busy0 = m_busy_cnt;
    ct0 = m_contend;
    start = 1'b1;
    @(posedge fabric_clk); #1;
    start = 1'b0;
    if (dbl) begin
      repeat (3) @(posedge fabric_clk);
      #1;
      start = 1'b1; transaction_length = 6'd2;
      @(posedge fabric_clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 600 && m_done_cnt == d0; i++) @(posedge fabric_clk);
    check("done_within_budget", 32'(m_done_cnt != d0), 32'd1);
    repeat (40) @(posedge fabric_clk);
    #1;
    res_done = m_done_cnt - d0;
    res_lat = m_done_cycle - m_acc_cycle;
    res_cs = m_cs_lo - cs0;
    res_oe = m_oe - oe0;
    res_rise = m_rise - rise0;
    res_busy = m_busy_cnt - busy0;
    res_contend = m_contend - ct0;
    res_sclk_end = spi_sclk;
    $display("txn cs=%0d H=%0d mode=%0d%0d N=%0d data=%h mask=%h -> rd=%h lat=%0d cs_lo=%0d",
             cs, div, cpol, cpha, len, data, mask, transaction_read_data, res_lat, res_cs);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge fabric_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'hF);
    check("rst_oe", 32'(spi_sdio_oe), 32'd0);
    check("rst_out", 32'(spi_sdio_out), 32'd0);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_rd", transaction_read_data, 32'd0);
    reset = 1'b0;

    // Write, mode 0, H=2, N=16
    run_txn(2'd1, 8'd2, 1'b0, 1'b0, 6'd16, 32'hA5C3, 32'hFFFF, 32'h0, 16, 1'b0);
    check("wr_rise", 32'(res_rise), 32'd16);
    check("wr_slave_rx", s_rx, 32'hA5C3);
    check("wr_cs_val", 32'(m_cs_val), 32'hD);
    check("wr_cs_len", 32'(res_cs), 32'd68);
    check("wr_done", 32'(res_done), 32'd1);
    check("wr_lat", 32'(res_lat), 32'd71);
    check("wr_oe", 32'(res_oe), 32'd64);
    check("wr_rd", transaction_read_data, 32'd0);
    check("wr_contend", 32'(res_contend), 32'd0);

    // Mixed read, H=1
    run_txn(2'd0, 8'd1, 1'b0, 1'b0, 6'd16, 32'h8000, 32'hFF00, 32'h005A, 16, 1'b0);
    check("mix_rd", transaction_read_data, 32'h005A);
    check("mix_oe", 32'(res_oe), 32'd16);
    check("mix_slave_rx", s_rx, 32'h8000);
    check("mix_lat", 32'(res_lat), 32'd36);

    // All four modes: a write of 0x3C, then a full read of 0xC6
    for (int m = 0; m < 4; m++) begin
      run_txn(2'd2, 8'd1, m[1], m[0], 6'd8, 32'h3C, 32'hFF, 32'h0, 8, 1'b0);
      check("mode_idle_sclk", 32'(m_sclk_idle), 32'(m[1]));
      check("mode_slave_rx", s_rx, 32'h3C);
      check("mode_rise", 32'(res_rise), 32'd8);
      check("mode_end_sclk", 32'(res_sclk_end), 32'(m[1]));
      check("mode_lat", 32'(res_lat), 32'd20);
      run_txn(2'd2, 8'd1, m[1], m[0], 6'd8, 32'h0, 32'h0, 32'hC6, 8, 1'b0);
      check("mode_rd", transaction_read_data, 32'hC6);
      check("mode_rd_oe", 32'(res_oe), 32'd0);
    end

    // start while busy is ignored; clk_div=0 acts as H=1
    run_txn(2'd0, 8'd0, 1'b0, 1'b0, 6'd4, 32'h0, 32'h0, 32'h9, 4, 1'b1);
    check("dbl_done", 32'(res_done), 32'd1);
    check("dbl_lat", 32'(res_lat), 32'd12);
    check("dbl_cs_len", 32'(res_cs), 32'd10);
    check("dbl_rd", transaction_read_data, 32'h9);

    // N=0: no bus activity, done 2 cycles after accept, read data cleared
    run_txn(2'd1, 8'd3, 1'b0, 1'b0, 6'd0, 32'hFF, 32'hFF, 32'h0, 0, 1'b0);
    check("n0_cs_len", 32'(res_cs), 32'd0);
    check("n0_lat", 32'(res_lat), 32'd2);
    check("n0_busy", 32'(res_busy), 32'd1);
    check("n0_done", 32'(res_done), 32'd1);
    check("n0_rd", transaction_read_data, 32'd0);

    // N=40 clamps to 32 bits
    run_txn(2'd0, 8'd1, 1'b0, 1'b0, 6'd40, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 32, 1'b0);
    check("n40_rise", 32'(res_rise), 32'd32);
    check("n40_slave_rx", s_rx, 32'hDEADBEEF);
    check("n40_lat", 32'(res_lat), 32'd68);
    check("n40_cs_len", 32'(res_cs), 32'd66);

    // cs_sel=7 on a 2-bit port lands on the last select
    run_txn(2'(3'd7), 8'd1, 1'b0, 1'b0, 6'd2, 32'h2, 32'h3, 32'h0, 2, 1'b0);
    check("cs7_val", 32'(m_cs_val), 32'h7);
    check("cs7_lat", 32'(res_lat), 32'd8);
    check("cs7_slave_rx", s_rx, 32'h2);

    // Reset during SHIFT
    begin
      int d0;
      @(posedge fabric_clk); #1;
      cs_sel = 2'd1; clk_div = 8'd2; spi_cpol = 1'b0; spi_cpha = 1'b0;
      transaction_length = 6'd16; transaction_data = 32'hFFFF; transaction_rw_mask = 32'hFFFF;
      s_n = 16; s_cpha = 1'b0; s_resp = '0;
      d0 = m_done_cnt;
      start = 1'b1;
      @(posedge fabric_clk); #1;
      start = 1'b0;
      repeat (20) @(posedge fabric_clk);
      #1;
      check("mid_cs_low_before_reset", 32'(spi_cs_n), 32'hD);
      reset = 1'b1;
      @(posedge fabric_clk); #1;
      check("mid_rst_cs_n", 32'(spi_cs_n), 32'hF);
      check("mid_rst_oe", 32'(spi_sdio_oe), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_sclk", 32'(spi_sclk), 32'd0);
      reset = 1'b0;
      repeat (150) @(posedge fabric_clk);
      #1;
      check("mid_rst_no_done", 32'(m_done_cnt - d0), 32'd0);
      $display("txn reset mid-shift -> cs_n=%h busy=%0d", spi_cs_n, busy);
    end

    // Fresh transaction after the abort, mode 3, H=2
    run_txn(2'd2, 8'd2, 1'b1, 1'b1, 6'd8, 32'h05, 32'h0F, 32'hA0, 8, 1'b0);
    check("post_rd", transaction_read_data, 32'hA0);
    check("post_slave_rx", s_rx, 32'h05);
    check("post_lat", 32'(res_lat), 32'd39);
    check("post_cs_len", 32'(res_cs), 32'd36);
    check("post_done", 32'(res_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
